// File: rtl/prio_pkt_sched_pkg.sv
// Shared types for the priority packet scheduler:
// FSM encoding, head-flag bit positions, index width helper.
package prio_pkt_sched_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_t;

  // Head flags are packed as {sop, eop, vld}.
  localparam int FLAG_SOP = 2;
  localparam int FLAG_EOP = 1;
  localparam int FLAG_VLD = 0;

  function automatic int prio_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/prio_pkt_sched_rr_pick.sv
// Combinational N-way picker: first ready index scanning from
// base_i (rr_i=1) or from 0 (rr_i=0). Ports: ready_i, base_i, rr_i -> idx_o, any_o.
module prio_rr_pick #(
  parameter int N = 8,
  parameter int W = 3
) (
  input  logic [N-1:0] ready_i,
  input  logic [W-1:0] base_i,
  input  logic         rr_i,
  output logic [W-1:0] idx_o,
  output logic         any_o
);

  always_comb begin
    int start;
    int j;
    idx_o = '0;
    any_o = 1'b0;
    start = rr_i ? int'(base_i) : 0;
    j     = 0;
    for (int k = 0; k < N; k++) begin
      j = (start + k) % N;
      if (!any_o && ready_i[j]) begin
        any_o = 1'b1;
        idx_o = W'(j);
      end
    end
  end

endmodule

// File: rtl/prio_pkt_sched.sv
// Packet scheduler: grants one queue per packet, pops beats via q_next_o,
// registered output stage with out_ready_i backpressure, stall watchdog.
// Ports: clk/rst, cfg_rr_i, q_* head inputs, q_next_o pops, out_* beat, busy_o, err_*_o.
module prio_pkt_sched
  import prio_pkt_sched_pkg::*;
#(
  parameter int N_PRIO = 8,
  parameter int DATA_W = 64,
  parameter int PRIO_W = 3,
  parameter int TO_W   = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cfg_rr_i,
  input  logic [N_PRIO-1:0]        q_ready_i,
  input  logic [N_PRIO-1:0]        q_sop_i,
  input  logic [N_PRIO-1:0]        q_eop_i,
  input  logic [N_PRIO-1:0]        q_vld_i,
  input  logic [N_PRIO*DATA_W-1:0] q_data_i,
  output logic [N_PRIO-1:0]        q_next_o,
  output logic                     out_sop_o,
  output logic                     out_eop_o,
  output logic                     out_vld_o,
  output logic [DATA_W-1:0]        out_data_o,
  output logic [PRIO_W-1:0]        out_prio_o,
  input  logic                     out_ready_i,
  output logic                     busy_o,
  output logic                     err_nosop_o,
  output logic                     err_timeout_o
);

  state_t              state_q;
  logic [PRIO_W-1:0]   grant_q;
  logic [PRIO_W-1:0]   rr_ptr_q;
  logic                mode_q;
  logic                first_q;
  logic [TO_W-1:0]     wd_q;
  logic [N_PRIO-1:0]   q_next_q;
  logic                out_sop_q;
  logic                out_eop_q;
  logic                out_vld_q;
  logic [DATA_W-1:0]   out_data_q;
  logic [PRIO_W-1:0]   out_prio_q;
  logic                busy_q;
  logic                err_nosop_q;
  logic                err_timeout_q;

  logic [PRIO_W-1:0]   pick_idx;
  logic                pick_any;
  logic [2:0]          hd_flags;
  logic [DATA_W-1:0]   hd_data;
  logic                hd_rdy;
  logic                out_free;
  logic                load;
  logic                wd_max;
  logic [N_PRIO-1:0]   grant_oh;
  logic [PRIO_W-1:0]   rr_next;

  prio_rr_pick #(
    .N (N_PRIO),
    .W (PRIO_W)
  ) u_pick (
    .ready_i (q_ready_i),
    .base_i  (rr_ptr_q),
    .rr_i    (cfg_rr_i),
    .idx_o   (pick_idx),
    .any_o   (pick_any)
  );

  assign hd_rdy   = q_ready_i[grant_q];
  assign hd_data  = q_data_i[int'(grant_q)*DATA_W +: DATA_W];
  assign hd_flags = {q_sop_i[grant_q], q_eop_i[grant_q], q_vld_i[grant_q]};
  assign out_free = !out_vld_q || out_ready_i;
  // A head popped last cycle has not settled yet: skip it.
  assign load     = hd_rdy && !q_next_q[grant_q] && out_free;
  assign wd_max   = &wd_q;
  assign grant_oh = N_PRIO'(1) << grant_q;
  assign rr_next  = (grant_q == PRIO_W'(N_PRIO-1)) ?
                    '0 : grant_q + PRIO_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      grant_q       <= '0;
      rr_ptr_q      <= '0;
      mode_q        <= 1'b0;
      first_q       <= 1'b0;
      wd_q          <= '0;
      q_next_q      <= '0;
      out_sop_q     <= 1'b0;
      out_eop_q     <= 1'b0;
      out_vld_q     <= 1'b0;
      out_data_q    <= '0;
      out_prio_q    <= '0;
      busy_q        <= 1'b0;
      err_nosop_q   <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      q_next_q <= '0;
      if (out_vld_q && out_ready_i) out_vld_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          // Wait for the last pop to settle so q_ready is current.
          if (pick_any && q_next_q == '0) begin
            grant_q <= pick_idx;
            mode_q  <= cfg_rr_i;
            first_q <= 1'b1;
            wd_q    <= '0;
            busy_q  <= 1'b1;
            state_q <= XFER;
          end
        end
        XFER: begin
          if (load) begin
            q_next_q <= grant_oh;
            wd_q     <= '0;
            if (first_q && !hd_flags[FLAG_SOP]) begin
              err_nosop_q <= 1'b1;
            end else begin
              first_q    <= 1'b0;
              out_sop_q  <= hd_flags[FLAG_SOP];
              out_eop_q  <= hd_flags[FLAG_EOP];
              out_vld_q  <= hd_flags[FLAG_VLD];
              out_data_q <= hd_data;
              out_prio_q <= grant_q;
              if (hd_flags[FLAG_EOP]) begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
                if (mode_q) rr_ptr_q <= rr_next;
              end
            end
          end else if (!hd_rdy) begin
            if (!wd_max) begin
              wd_q <= wd_q + TO_W'(1);
            end else if (out_free) begin
              // Close the broken packet with a synthetic eop.
              err_timeout_q <= 1'b1;
              out_sop_q     <= 1'b0;
              out_eop_q     <= 1'b1;
              out_vld_q     <= 1'b1;
              out_data_q    <= '0;
              out_prio_q    <= grant_q;
              state_q       <= IDLE;
              busy_q        <= 1'b0;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign q_next_o      = q_next_q;
  assign out_sop_o     = out_sop_q;
  assign out_eop_o     = out_eop_q;
  assign out_vld_o     = out_vld_q;
  assign out_data_o    = out_data_q;
  assign out_prio_o    = out_prio_q;
  assign busy_o        = busy_q;
  assign err_nosop_o   = err_nosop_q;
  assign err_timeout_o = err_timeout_q;

endmodule
